sm83_instr_assembler: RTL and testbench
=======================================

// Module: sm83_instr_assembler
// PURPOSE
// - Sits between the fetch byte stream and decode. It turns raw opcode bytes into whole SM83
//   instructions: opcode, CB-prefix flag, 8/16-bit immediate, length and start PC.
// - Tracks the 0xCB prefix internally, so decode no longer needs i_is_instr16 feedback.
// - Buffers up to DEPTH assembled instructions, so fetch can run ahead of decode/execute.
// PARAMETERS
// - DEPTH  4   number of assembled-instruction queue entries; power of 2, >=2
// - PC_W   16  PC width
// PORTS
// - clk            in   1       clock, rising edge
// - rst_n          in   1       asynchronous active-low reset
// - i_flush        in   1       discard the queue and any partial instruction (taken branch/IRQ)
// - i_flush_pc     in   PC_W    PC of the next byte after a flush
// - i_byte_valid   in   1       fetch byte valid
// - o_byte_ready   out  1       assembler accepts the byte this cycle
// - i_byte         in   8       fetched byte
// - o_instr_valid  out  1       queue head valid
// - i_instr_ready  in   1       decode consumes the head
// - o_opcode       out  8       head opcode; the byte after 0xCB when o_is_cb=1
// - o_is_cb        out  1       head is a CB-prefixed instruction
// - o_imm          out  16      head immediate; an 8-bit immediate is zero-extended
// - o_len          out  2       head length in bytes, 1..3
// - o_pc           out  PC_W    PC of the head's first byte
// - o_illegal      out  1       head opcode is unused: D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD
// - o_count        out  $clog2(DEPTH)+1   queue occupancy
// BEHAVIOUR
// - Reset (async on rst_n low):
//   - FSM=S_OP, queue empty, pc=0.
//   - All outputs 0 except o_byte_ready=1.
// - Handshakes:
//   - A byte transfers when i_byte_valid && o_byte_ready.
//   - A queue entry pops when o_instr_valid && i_instr_ready.
// - o_byte_ready = !full. Registered from occupancy; no same-cycle pass-through of a pop when full.
// - Every accepted byte increments the internal pc by 1, wrapping mod 2**PC_W.
// - FSM (advances only on an accepted byte):
//   - S_OP:
//     - Latch the opcode and start_pc = pc.
//     - 0xCB -> S_CB.
//     - Length 1 -> push now, stay in S_OP.
//     - Length 2/3 -> S_IMM_LO.
//   - S_CB: latch the byte as opcode, is_cb=1, len=2, push, -> S_OP.
//   - S_IMM_LO:
//     - imm[7:0] = byte.
//     - Length 2 -> push with imm[15:8]=0, -> S_OP.
//     - Length 3 -> S_IMM_HI.
//   - S_IMM_HI: imm[15:8] = byte, push, -> S_OP.
// - Length table sm83_instr_len(op):
//   - Length 3: 01,11,21,31,08, C2,C3,C4,CA,CC,CD, D2,D4,DA,DC, EA,FA.
//   - Length 2: 06,0E,16,1E,26,2E,36,3E, 18,20,28,30,38, C6,CE,D6,DE,E6,EE,F6,FE, E0,F0,E8,F8, and 10 (STOP).
//   - Length 1: everything else, including illegal opcodes.
// - STOP's second byte is consumed as imm[7:0] and carried unchanged.
// - Push latency: the completing byte is accepted in cycle N; the entry is visible at the head
//   in cycle N+1 if the queue was empty.
// - Queue:
//   - Simultaneous push and pop in one cycle: count unchanged.
//   - Pointers wrap mod DEPTH.
//   - Head outputs hold stable while o_instr_valid && !i_instr_ready.
// - Flush (highest priority):
//   - Queue is emptied and FSM -> S_OP. Partial state is discarded, including a pending CB prefix.
//   - pc <= i_flush_pc.
//   - Any byte or pop offered in the flush cycle is ignored.
//   - Next cycle: o_instr_valid=0, o_byte_ready=1.
// - A reset mid-instruction drops the partial state, same as a flush with pc=0.
// STRUCTURE
// - sm83_pkg additions:
//   - asm_state_t enum {S_OP,S_CB,S_IMM_LO,S_IMM_HI}.
//   - asm_instr_t struct {opcode,is_cb,imm,len,pc,illegal}.
//   - function sm83_instr_len.
//   - function sm83_is_illegal.
// - Sub-module sm83_instr_fifo #(DEPTH, type T=asm_instr_t): synchronous FIFO with async
//   reset, flush, push/pop and count.
// - Top level holds the FSM, the assembly registers and the pc counter.
// TESTING
// - Length 3: bytes 01,34,12 from pc=0x0100 -> one entry {op=01,imm=1234,len=3,pc=0100,is_cb=0}.
// - CB prefix: bytes CB,37 -> {op=37,is_cb=1,len=2,imm=0000}.
//   Also CB then flush, then 37 -> {op=37,is_cb=0,len=1}.
// - Back-pressure, DEPTH=4, i_instr_ready=0: stream 00x6 ->
//   - count=4 and o_byte_ready=0 after the 4th byte.
//   - Raise ready for one cycle -> pop 1, count=3, o_byte_ready=1 the next cycle.
// - Illegal and STOP: D3 -> {len=1,illegal=1}; 10,00 -> {op=10,len=2,imm=0000}.
// - Flush mid-immediate: bytes C3,00, then flush with pc=0x0200, then 3E,55 ->
//   only entry {op=3E,imm=0055,len=2,pc=0200}.
// - Async reset mid-assembly (after C3), with rst_n low off a clock edge ->
//   - outputs 0 immediately, o_byte_ready=1.
//   - After release, 00 -> {pc=0000,len=1}.

Source files
------------

// File: rtl/sm83_instr_assembler_pkg.sv
// sm83_instr_assembler_pkg: types and opcode tables for the SM83 instruction assembler
package sm83_instr_assembler_pkg;

    localparam int ASM_PC_W = 16;

    typedef enum logic [1:0] {
        S_OP,
        S_CB,
        S_IMM_LO,
        S_IMM_HI
    } asm_state_t;

    typedef struct packed {
        logic [7:0]          opcode;
        logic                is_cb;
        logic [15:0]         imm;
        logic [1:0]          len;
        logic [ASM_PC_W-1:0] pc;
        logic                illegal;
    } asm_instr_t;

    function automatic logic [1:0] sm83_instr_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
            8'hD2, 8'hD4, 8'hDA, 8'hDC,
            8'hEA, 8'hFA: return 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8,
            8'h10: return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic sm83_is_illegal(input logic [7:0] op);
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sm83_instr_fifo.sv
// sm83_instr_fifo: small synchronous FIFO with async reset, flush and occupancy count
module sm83_instr_fifo
    import sm83_instr_assembler_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = asm_instr_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // storage array; contents are don't-care until written, the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/sm83_instr_assembler.sv
// sm83_instr_assembler: assembles fetched SM83 bytes into whole instructions and queues them for decode
module sm83_instr_assembler
    import sm83_instr_assembler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic [PC_W-1:0]          i_flush_pc,
    input  logic                     i_byte_valid,
    output logic                     o_byte_ready,
    input  logic [7:0]               i_byte,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready,
    output logic [7:0]               o_opcode,
    output logic                     o_is_cb,
    output logic [15:0]              o_imm,
    output logic [1:0]               o_len,
    output logic [PC_W-1:0]          o_pc,
    output logic                     o_illegal,
    output logic [$clog2(DEPTH):0]   o_count
);

    asm_state_t      state, state_nxt;
    logic [7:0]      op_q, imm_lo_q;
    logic [PC_W-1:0] pc, start_pc;
    logic            byte_acc, push, full, empty;
    asm_instr_t      push_d, head;

    assign byte_acc = i_byte_valid && o_byte_ready && !i_flush;

    // decide the next state and build the entry completed by the byte accepted this cycle
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_d    = '0;
        push_d.pc = ASM_PC_W'(start_pc);
        if (byte_acc) begin
            case (state)
                S_OP: begin
                    push_d.opcode  = i_byte;
                    push_d.pc      = ASM_PC_W'(pc);
                    push_d.len     = 2'd1;
                    push_d.illegal = sm83_is_illegal(i_byte);
                    push           = i_byte != 8'hCB && sm83_instr_len(i_byte) == 2'd1;
                    state_nxt      = i_byte == 8'hCB ? S_CB : push ? S_OP : S_IMM_LO;
                end
                S_CB: begin
                    push_d.opcode = i_byte;
                    push_d.is_cb  = 1'b1;
                    push_d.len    = 2'd2;
                    push          = 1'b1;
                    state_nxt     = S_OP;
                end
                S_IMM_LO: begin
                    push_d.opcode = op_q;
                    push_d.imm    = {8'h00, i_byte};
                    push_d.len    = 2'd2;
                    push          = sm83_instr_len(op_q) == 2'd2;
                    state_nxt     = push ? S_OP : S_IMM_HI;
                end
                S_IMM_HI: begin
                    push_d.opcode = op_q;
                    push_d.imm    = {i_byte, imm_lo_q};
                    push_d.len    = 2'd3;
                    push          = 1'b1;
                    state_nxt     = S_OP;
                end
                default: state_nxt = S_OP;
            endcase
        end
    end

    // FSM state, partial-instruction registers and the running byte pc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_OP;
            op_q     <= '0;
            imm_lo_q <= '0;
            pc       <= '0;
            start_pc <= '0;
        end else if (i_flush) begin
            state <= S_OP;
            pc    <= i_flush_pc;
        end else if (byte_acc) begin
            state <= state_nxt;
            pc    <= pc + PC_W'(1);
            if (state == S_OP) begin
                op_q     <= i_byte;
                start_pc <= pc;
            end
            if (state == S_IMM_LO) imm_lo_q <= i_byte;
        end
    end

    sm83_instr_fifo #(
        .DEPTH (DEPTH),
        .T     (asm_instr_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_flush),
        .push  (push),
        .din   (push_d),
        .pop   (i_instr_ready),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (o_count)
    );

    assign o_byte_ready  = !full;
    assign o_instr_valid = !empty;
    assign o_opcode      = head.opcode;
    assign o_is_cb       = head.is_cb;
    assign o_imm         = head.imm;
    assign o_len         = head.len;
    assign o_pc          = head.pc[PC_W-1:0];
    assign o_illegal     = head.illegal;

endmodule

// File: tb/tb_sm83_instr_assembler.sv
// tb_sm83_instr_assembler: scoreboard bench with a byte-list reference model of SM83 instruction assembly
module tb_sm83_instr_assembler;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_flush = 1'b0;
    logic [PC_W-1:0]        i_flush_pc = '0;
    logic                   i_byte_valid = 1'b0;
    logic [7:0]             i_byte = '0;
    logic                   i_instr_ready = 1'b0;
    logic                   o_byte_ready, o_instr_valid, o_is_cb, o_illegal;
    logic [7:0]             o_opcode;
    logic [15:0]            o_imm;
    logic [1:0]             o_len;
    logic [PC_W-1:0]        o_pc;
    logic [$clog2(DEPTH):0] o_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        int          len;
        logic [15:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  part[$];
    logic [15:0] m_pc = '0;
    logic [15:0] m_start = '0;
    logic        rdy_s = 1'b0;

    logic [7:0] len3 [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
                              8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA};
    logic [7:0] len2 [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h18,
                              8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6,
                              8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'h10};
    logic [7:0] ill  [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4,
                              8'hFC, 8'hFD};

    sm83_instr_assembler #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_flush_pc    (i_flush_pc),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .i_byte        (i_byte),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_opcode      (o_opcode),
        .o_is_cb       (o_is_cb),
        .o_imm         (o_imm),
        .o_len         (o_len),
        .o_pc          (o_pc),
        .o_illegal     (o_illegal),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    function automatic int ref_len(input logic [7:0] op);
        foreach (len3[i]) if (len3[i] == op) return 3;
        foreach (len2[i]) if (len2[i] == op) return 2;
        return 1;
    endfunction

    function automatic logic ref_ill(input logic [7:0] op);
        foreach (ill[i]) if (ill[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // reference model: gathers accepted bytes into an instruction and queues the expected entry
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            part.delete();
            m_pc = '0;
        end else if (i_flush) begin
            sb.delete();
            part.delete();
            m_pc = i_flush_pc;
        end else if (i_byte_valid && rdy_s) begin
            exp_t e;
            int   n;
            if (part.size() == 0) m_start = m_pc;
            part.push_back(i_byte);
            m_pc = m_pc + 16'd1;
            n = part[0] == 8'hCB ? 2 : ref_len(part[0]);
            if (part.size() == n) begin
                e.pc = m_start;
                if (part[0] == 8'hCB) begin
                    e.op = part[1]; e.cb = 1'b1; e.imm = 16'h0000; e.len = 2; e.ill = 1'b0;
                end else begin
                    e.op = part[0]; e.cb = 1'b0; e.len = n; e.ill = ref_ill(part[0]);
                    e.imm = n == 3 ? {part[2], part[1]} : n == 2 ? {8'h00, part[1]} : 16'h0000;
                end
                sb.push_back(e);
                part.delete();
            end
        end
    end

    // monitor: compares the presented head against the scoreboard and retires it on a pop
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(o_count), sb.size());
            chk("byte_ready", 32'(o_byte_ready), 32'(sb.size() < DEPTH));
            chk("instr_valid", 32'(o_instr_valid), 32'(sb.size() != 0));
            if (sb.size() != 0 && o_instr_valid) begin
                chk("head_op", 32'(o_opcode), 32'(sb[0].op));
                chk("head_cb", 32'(o_is_cb), 32'(sb[0].cb));
                chk("head_imm", 32'(o_imm), 32'(sb[0].imm));
                chk("head_len", 32'(o_len), sb[0].len);
                chk("head_pc", 32'(o_pc), 32'(sb[0].pc));
                chk("head_ill", 32'(o_illegal), 32'(sb[0].ill));
                if (i_instr_ready) void'(sb.pop_front());
            end
        end
        rdy_s = o_byte_ready;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic acc = 1'b0;
        i_byte_valid = 1'b1;
        i_byte = b;
        while (!acc && n < 200) begin
            @(posedge clk);
            acc = rdy_s;
            n++;
        end
        #1;
        i_byte_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic do_flush(input logic [15:0] p);
        i_flush = 1'b1;
        i_flush_pc = p;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("flush_valid", 32'(o_instr_valid), 0);
        chk("flush_ready", 32'(o_byte_ready), 1);
    endtask

    task automatic expect_head(input string n, input logic [7:0] op, input logic cb,
                               input logic [15:0] imm, input logic [1:0] len,
                               input logic [15:0] pc, input logic il);
        int k = 0;
        while (!o_instr_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({n, "_valid"}, 32'(o_instr_valid), 1);
        chk({n, "_op"}, 32'(o_opcode), 32'(op));
        chk({n, "_cb"}, 32'(o_is_cb), 32'(cb));
        chk({n, "_imm"}, 32'(o_imm), 32'(imm));
        chk({n, "_len"}, 32'(o_len), 32'(len));
        chk({n, "_pc"}, 32'(o_pc), 32'(pc));
        chk({n, "_ill"}, 32'(o_illegal), 32'(il));
        i_instr_ready = 1'b1;
        @(posedge clk);
        #1;
        i_instr_ready = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(o_byte_ready), 1);
        chk("rst_valid", 32'(o_instr_valid), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_op", 32'(o_opcode), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_flush(16'h0100);
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
        expect_head("len3", 8'h01, 1'b0, 16'h1234, 2'd3, 16'h0100, 1'b0);
        send_byte(8'hCB); send_byte(8'h37);
        expect_head("cb", 8'h37, 1'b1, 16'h0000, 2'd2, 16'h0103, 1'b0);
        send_byte(8'hCB);
        do_flush(16'h0300);
        send_byte(8'h37);
        expect_head("cb_flush", 8'h37, 1'b0, 16'h0000, 2'd1, 16'h0300, 1'b0);
        repeat (4) send_byte(8'h00);
        chk("bp_count4", 32'(o_count), 4);
        chk("bp_ready0", 32'(o_byte_ready), 0);
        i_byte_valid = 1'b1;
        i_byte = 8'h00;
        @(posedge clk);
        #1;
        chk("bp_hold4", 32'(o_count), 4);
        i_instr_ready = 1'b1;
        @(posedge clk);
        #1;
        i_instr_ready = 1'b0;
        chk("bp_count3", 32'(o_count), 3);
        chk("bp_ready1", 32'(o_byte_ready), 1);
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        chk("bp_refill4", 32'(o_count), 4);
        i_instr_ready = 1'b1;
        send_byte(8'h00);
        repeat (8) @(posedge clk);
        #1;
        i_instr_ready = 1'b0;
        chk("bp_drained", 32'(o_count), 0);
        do_flush(16'h0400);
        send_byte(8'hD3);
        expect_head("illegal", 8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0400, 1'b1);
        send_byte(8'h10); send_byte(8'h00);
        expect_head("stop", 8'h10, 1'b0, 16'h0000, 2'd2, 16'h0401, 1'b0);
        send_byte(8'hC3); send_byte(8'h00);
        do_flush(16'h0200);
        send_byte(8'h3E); send_byte(8'h55);
        expect_head("flush_imm", 8'h3E, 1'b0, 16'h0055, 2'd2, 16'h0200, 1'b0);
        chk("flush_imm_only", 32'(o_instr_valid), 0);
        send_byte(8'h00);
        send_byte(8'hC3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_instr_valid), 0);
        chk("arst_ready", 32'(o_byte_ready), 1);
        chk("arst_count", 32'(o_count), 0);
        chk("arst_op", 32'(o_opcode), 0);
        chk("arst_pc", 32'(o_pc), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h00);
        expect_head("arst_after", 8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 7);
            i_byte_valid = $urandom_range(0, 3) != 0;
            i_byte = r == 0 ? 8'hCB : r < 3 ? len3[$urandom_range(0, 16)] :
                     r < 5 ? len2[$urandom_range(0, 25)] : 8'($urandom_range(0, 255));
            i_instr_ready = (c / 300) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            i_flush = $urandom_range(0, 63) == 0;
            i_flush_pc = 16'($urandom);
            @(posedge clk);
            #1;
        end
        i_byte_valid = 1'b0;
        i_flush = 1'b0;
        i_instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_empty", 32'(o_count), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
